// File: rtl/sudoku_uart_loader.sv
// UART puzzle loader: 8N1 receiver plus ASCII digit parser.
// Emits one grid write per accepted digit, row-major 9x9.
module sudoku_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CELLS    = 81
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       RxD,
    output logic       WrEn,
    output logic [3:0] WrRow,
    output logic [3:0] WrCol,
    output logic [3:0] WrValue,
    output logic       Loading,
    output logic       Done,
    output logic       FrameErr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [6:0] LAST_CELL = 7'(NUM_CELLS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          meta_q, rxs_q, rxs_prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_vld_q, byte_vld_d;
    logic          ferr_q, ferr_d;

    logic          wr_en_q, wr_en_d;
    logic [3:0]    wr_row_q, wr_row_d;
    logic [3:0]    wr_col_q, wr_col_d;
    logic [3:0]    wr_val_q, wr_val_d;
    logic          loading_q, loading_d;
    logic          done_q, done_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic [6:0]    cell_q, cell_d;

    logic          is_digit, is_esc;
    logic [3:0]    digit_val;

    // Two-flop synchronizer plus a delayed copy for start-edge detection.
    // Held at idle-high in reset so leaving reset never looks like a start bit.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            meta_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            meta_q     <= RxD;
            rxs_q      <= meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receiver next-state: mid-bit sampling, LSB first, exit at mid stop bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        ferr_d     = ferr_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rxs_q) byte_vld_d = 1'b1;
                    else       ferr_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
        end
    end

    // Byte classification; shift_q is stable while byte_vld_q is high.
    always_comb begin
        is_esc    = (shift_q == 8'h1B);
        is_digit  = (shift_q == 8'h2E) ||
                    (shift_q >= 8'h30 && shift_q <= 8'h39);
        digit_val = (shift_q == 8'h2E) ? 4'd0 : shift_q[3:0];
    end

    // Parser next-state: write strobe, cell counters, load status.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_val_d  = wr_val_q;
        loading_d = loading_q;
        done_d    = done_q;
        row_d     = row_q;
        col_d     = col_q;
        cell_d    = cell_q;
        if (byte_vld_q) begin
            if (is_digit) begin
                wr_en_d  = 1'b1;
                wr_row_d = row_q;
                wr_col_d = col_q;
                wr_val_d = digit_val;
                if (cell_q == LAST_CELL) begin
                    row_d     = '0;
                    col_d     = '0;
                    cell_d    = '0;
                    done_d    = 1'b1;
                    loading_d = 1'b0;
                end else begin
                    cell_d    = cell_q + 1'b1;
                    done_d    = 1'b0;
                    loading_d = 1'b1;
                    if (col_q == 4'd8) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end else if (is_esc) begin
                row_d     = '0;
                col_d     = '0;
                cell_d    = '0;
                loading_d = 1'b0;
            end
        end
    end

    // Parser registers; write outputs hold their last value between strobes.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_val_q  <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            cell_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_val_q  <= wr_val_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cell_q    <= cell_d;
        end
    end

    assign WrEn     = wr_en_q;
    assign WrRow    = wr_row_q;
    assign WrCol    = wr_col_q;
    assign WrValue  = wr_val_q;
    assign Loading  = loading_q;
    assign Done     = done_q;
    assign FrameErr = ferr_q;

endmodule
